// File: rtl/ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_pkg.sv
// Shared constants for the PCG write dispatch-rotate controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_pkg;

  // FSM encoding, kept as plain constants for compatibility with older tools
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Rotate datapath depth S0->S3; the write pipe must match it exactly
  function automatic int get_latency();
    return 3;
  endfunction

  localparam int ROT_LAT = get_latency();

  // Register width for a field counting 0..n-1, never narrower than one bit
  function automatic int fld_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default geometry and the address fields derived from it
  localparam int DEF_CHUNK_NB     = 64;
  localparam int DEF_BATCH_PBS_NB = 8;
  localparam int DEF_ROT_NB       = 16;
  localparam int DEF_BUF_DEPTH    = 2;
  localparam int DEF_BID_W        = 4;

  localparam int DEF_CHUNK_W = $clog2(DEF_CHUNK_NB);
  localparam int DEF_PBS_W   = fld_w(DEF_BATCH_PBS_NB);
  localparam int DEF_SLOT_W  = fld_w(DEF_BUF_DEPTH);
  localparam int DEF_ADDR_W  = $clog2(DEF_BUF_DEPTH * DEF_BATCH_PBS_NB * DEF_CHUNK_NB);

endpackage

// File: rtl/ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_dly.sv
// Fixed-depth valid+payload shift pipe, cleared asynchronously.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; advances every cycle, reset drops everything in flight.
module ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_dly
  import ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_pkg::*;
#(
  parameter int DEPTH = ROT_LAT,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         a_rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         any_vld
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  // Shift valid and payload one stage per cycle
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl.sv
// Sequences one batch at a time: rotation command per beat, RAM write LAT cycles later.
// Latency: rot_* combinational on the accepted beat; wr_* exactly LAT cycles after it.
// Backpressure: cmd_rdy needs IDLE and a free buffer credit; in_rdy is high only in RUN.
module ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl
  import ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_pkg::*;
#(
  parameter int CHUNK_NB     = DEF_CHUNK_NB,
  parameter int BATCH_PBS_NB = DEF_BATCH_PBS_NB,
  parameter int ROT_NB       = DEF_ROT_NB,
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int LAT          = ROT_LAT,
  parameter int BID_W        = DEF_BID_W
) (
  input  logic                                               clk,
  input  logic                                               a_rst_n,
  input  logic                                               cmd_vld,
  output logic                                               cmd_rdy,
  input  logic [BID_W-1:0]                                   cmd_bid,
  input  logic [$clog2(BATCH_PBS_NB):0]                      cmd_pbs_nb,
  input  logic                                               in_vld,
  output logic                                               in_rdy,
  output logic                                               rot_avail,
  output logic [$clog2(ROT_NB)-1:0]                          rot_factor,
  output logic                                               rot_sob,
  output logic                                               rot_eob,
  output logic                                               wr_en,
  output logic [$clog2(BUF_DEPTH*BATCH_PBS_NB*CHUNK_NB)-1:0] wr_add,
  output logic [BID_W-1:0]                                   wr_bid,
  input  logic                                               credit_ret,
  output logic                                               busy,
  output logic                                               err_ovf
);

  localparam int CHUNK_W = $clog2(CHUNK_NB);
  localparam int PBS_SH  = $clog2(BATCH_PBS_NB);
  localparam int PBS_W   = fld_w(BATCH_PBS_NB);
  localparam int SLOT_W  = fld_w(BUF_DEPTH);
  localparam int PNB_W   = $clog2(BATCH_PBS_NB) + 1;
  localparam int ROT_W   = $clog2(ROT_NB);
  localparam int ADDR_W  = $clog2(BUF_DEPTH * BATCH_PBS_NB * CHUNK_NB);
  localparam int CRED_W  = $clog2(BUF_DEPTH + 1);
  localparam int PAY_W   = ADDR_W + BID_W;

  logic [0:0]         state_q;
  logic [BID_W-1:0]   bid_q;
  logic [PNB_W-1:0]   pnb_q;
  logic [CHUNK_W-1:0] chunk_q;
  logic [PBS_W-1:0]   pbs_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [CRED_W-1:0]  credit_q;
  logic               err_q;

  logic               cmd_acc;
  logic               beat_acc;
  logic               last_chunk;
  logic               last_beat;
  logic [CHUNK_W:0]   rot_sum;
  logic [ADDR_W-1:0]  beat_add;
  logic               dly_vld;
  logic [PAY_W-1:0]   dly_dat;
  logic               dly_any;

  assign cmd_rdy    = (state_q == ST_IDLE) && (credit_q != '0);
  assign cmd_acc    = cmd_vld && cmd_rdy;
  assign in_rdy     = (state_q == ST_RUN);
  assign beat_acc   = in_vld && in_rdy;
  assign last_chunk = (chunk_q == CHUNK_W'(CHUNK_NB - 1));
  assign last_beat  = last_chunk && (PNB_W'(pbs_q) == (pnb_q - PNB_W'(1)));

  // Rotation amount wraps on ROT_NB; only the low bits of chunk+pbs matter
  assign rot_sum    = {1'b0, chunk_q} + (CHUNK_W+1)'(pbs_q);
  assign rot_avail  = beat_acc;
  assign rot_factor = beat_acc ? rot_sum[ROT_W-1:0] : '0;
  assign rot_sob    = beat_acc && (chunk_q == '0) && (pbs_q == '0);
  assign rot_eob    = beat_acc && last_beat;

  // Buffer address is {slot, pbs, chunk}; the slot field vanishes when BUF_DEPTH is 1
  assign beat_add = (ADDR_W'(slot_q) << (PBS_SH + CHUNK_W))
                  | (ADDR_W'(pbs_q) << CHUNK_W)
                  | ADDR_W'(chunk_q);

  // Batch FSM and beat counters; a new command is only seen from IDLE, giving one idle cycle after each batch
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= ST_IDLE;
      bid_q   <= '0;
      pnb_q   <= '0;
      chunk_q <= '0;
      pbs_q   <= '0;
      slot_q  <= '0;
    end else if (cmd_acc) begin
      state_q <= ST_RUN;
      bid_q   <= cmd_bid;
      pnb_q   <= cmd_pbs_nb;
      chunk_q <= '0;
      pbs_q   <= '0;
    end else if (beat_acc) begin
      if (last_chunk) begin
        chunk_q <= '0;
        pbs_q   <= pbs_q + 1'b1;
      end else begin
        chunk_q <= chunk_q + 1'b1;
      end
      if (last_beat) begin
        state_q <= ST_IDLE;
        slot_q  <= (slot_q == SLOT_W'(BUF_DEPTH - 1)) ? '0 : slot_q + 1'b1;
      end
    end
  end

  // Credit pool: take one per command, give one back per return; an excess return is flagged and dropped
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      credit_q <= CRED_W'(BUF_DEPTH);
      err_q    <= 1'b0;
    end else if (credit_ret && !cmd_acc) begin
      if (credit_q == CRED_W'(BUF_DEPTH)) err_q <= 1'b1;
      else                                credit_q <= credit_q + 1'b1;
    end else if (cmd_acc && !credit_ret) begin
      credit_q <= credit_q - 1'b1;
    end
  end

  ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_dly #(
    .DEPTH (LAT),
    .W     (PAY_W)
  ) u_dly (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .in_vld  (beat_acc),
    .in_dat  ({bid_q, beat_add}),
    .out_vld (dly_vld),
    .out_dat (dly_dat),
    .any_vld (dly_any)
  );

  // Address and bid are held at zero outside write cycles
  assign wr_en   = dly_vld;
  assign wr_add  = dly_vld ? dly_dat[ADDR_W-1:0] : '0;
  assign wr_bid  = dly_vld ? dly_dat[PAY_W-1:ADDR_W] : '0;

  assign busy    = (state_q != ST_IDLE) || dly_any;
  assign err_ovf = err_q;

endmodule

// File: tb/tb_ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl.sv
// Directed bench for the PCG write dispatch-rotate controller.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl;

  localparam int CHUNK_NB     = 64;
  localparam int BATCH_PBS_NB = 8;
  localparam int ROT_NB       = 16;
  localparam int BUF_DEPTH    = 2;
  localparam int LAT          = 3;
  localparam int BID_W        = 4;
  localparam int PNB_W        = $clog2(BATCH_PBS_NB) + 1;
  localparam int ROT_W        = $clog2(ROT_NB);
  localparam int ADDR_W       = $clog2(BUF_DEPTH * BATCH_PBS_NB * CHUNK_NB);

  logic              clk = 1'b0;
  logic              a_rst_n;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [BID_W-1:0]  cmd_bid;
  logic [PNB_W-1:0]  cmd_pbs_nb;
  logic              in_vld;
  logic              in_rdy;
  logic              rot_avail;
  logic [ROT_W-1:0]  rot_factor;
  logic              rot_sob;
  logic              rot_eob;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_add;
  logic [BID_W-1:0]  wr_bid;
  logic              credit_ret;
  logic              busy;
  logic              err_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl #(
    .CHUNK_NB     (CHUNK_NB),
    .BATCH_PBS_NB (BATCH_PBS_NB),
    .ROT_NB       (ROT_NB),
    .BUF_DEPTH    (BUF_DEPTH),
    .LAT          (LAT),
    .BID_W        (BID_W)
  ) dut (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_bid    (cmd_bid),
    .cmd_pbs_nb (cmd_pbs_nb),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .rot_avail  (rot_avail),
    .rot_factor (rot_factor),
    .rot_sob    (rot_sob),
    .rot_eob    (rot_eob),
    .wr_en      (wr_en),
    .wr_add     (wr_add),
    .wr_bid     (wr_bid),
    .credit_ret (credit_ret),
    .busy       (busy),
    .err_ovf    (err_ovf)
  );

  typedef struct {
    int cmd_vld; int bid; int pnb; int in_vld; int cr;
    int e_cmd_rdy; int e_in_rdy; int e_avail; int e_factor; int e_sob; int e_eob;
    int e_wr_en; int e_wr_add; int e_wr_bid; int e_busy; int e_err;
  } vec_t;

  localparam int NV = 12;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_vld    = 1'b0;
    cmd_bid    = '0;
    cmd_pbs_nb = '0;
    in_vld     = 1'b0;
    credit_ret = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    a_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input int bid, input int pnb);
    cmd_vld    = 1'b1;
    cmd_bid    = BID_W'(bid);
    cmd_pbs_nb = PNB_W'(pnb);
    @(negedge clk);
    chk("cmd_accept_rdy", 32'(cmd_rdy), 32'd1);
    tick();
    cmd_vld = 1'b0;
  endtask

  // Full batch with in_vld held high, then drain the write pipe
  task automatic run_batch(input int pnb, input int base, input int bid, input int exp_rdy_after);
    int n;
    n = pnb * CHUNK_NB;
    for (int k = 0; k < n; k++) begin
      in_vld = 1'b1;
      @(negedge clk);
      chk("run_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("run_avail", 32'(rot_avail), 32'd1);
      chk("run_factor", 32'(rot_factor), 32'(((k % CHUNK_NB) + (k / CHUNK_NB)) % ROT_NB));
      chk("run_sob", 32'(rot_sob), 32'(k == 0));
      chk("run_eob", 32'(rot_eob), 32'(k == n - 1));
      chk("run_wr_en", 32'(wr_en), 32'(k >= LAT));
      if (k >= LAT) begin
        chk("run_wr_add", 32'(wr_add), 32'(base + k - LAT));
        chk("run_wr_bid", 32'(wr_bid), 32'(bid));
      end
      tick();
    end
    in_vld = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("post_cmd_rdy", 32'(cmd_rdy), 32'(exp_rdy_after));
        chk("post_in_rdy", 32'(in_rdy), 32'd0);
      end
      chk("drain_wr_en", 32'(wr_en), 32'd1);
      chk("drain_wr_add", 32'(wr_add), 32'(base + n - LAT + j));
      chk("drain_busy", 32'(busy), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("done_wr_en", 32'(wr_en), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           cv bid pnb iv cr | rdy ird av fac sob eob wen wadd wbid busy err
    tv[0]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 3, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 1, 0,  0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0};
    tv[3]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[4]  = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    tv[5]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 3, 1, 0};
    tv[6]  = '{0, 0, 0, 1, 0,  0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0};
    tv[7]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 3, 1, 0};
    tv[8]  = '{0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[9]  = '{0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1, 2, 3, 1, 0};
    tv[10] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[11] = '{1, 9, 2, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    idle_inputs();
    a_rst_n = 1'b0;
    do_reset();

    // Reset state, toggled in_vld, credit return and overflow, all from the table
    for (int i = 0; i < NV; i++) begin
      cmd_vld    = tv[i].cmd_vld[0];
      cmd_bid    = BID_W'(tv[i].bid);
      cmd_pbs_nb = PNB_W'(tv[i].pnb);
      in_vld     = tv[i].in_vld[0];
      credit_ret = tv[i].cr[0];
      @(negedge clk);
      chk($sformatf("tv%0d_cmd_rdy", i), 32'(cmd_rdy), 32'(tv[i].e_cmd_rdy));
      chk($sformatf("tv%0d_in_rdy", i), 32'(in_rdy), 32'(tv[i].e_in_rdy));
      chk($sformatf("tv%0d_avail", i), 32'(rot_avail), 32'(tv[i].e_avail));
      if (tv[i].e_avail != 0 || i == 0) begin
        chk($sformatf("tv%0d_factor", i), 32'(rot_factor), 32'(tv[i].e_factor));
        chk($sformatf("tv%0d_sob", i), 32'(rot_sob), 32'(tv[i].e_sob));
        chk($sformatf("tv%0d_eob", i), 32'(rot_eob), 32'(tv[i].e_eob));
      end
      chk($sformatf("tv%0d_wr_en", i), 32'(wr_en), 32'(tv[i].e_wr_en));
      if (tv[i].e_wr_en != 0 || i == 0) begin
        chk($sformatf("tv%0d_wr_add", i), 32'(wr_add), 32'(tv[i].e_wr_add));
        chk($sformatf("tv%0d_wr_bid", i), 32'(wr_bid), 32'(tv[i].e_wr_bid));
      end
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("tv%0d_err", i), 32'(err_ovf), 32'(tv[i].e_err));
      tick();
    end
    idle_inputs();

    // Finish the table's batch: chunk resumes at 3 and ends with eob at 63
    for (int k = 3; k < CHUNK_NB; k++) begin
      in_vld = 1'b1;
      @(negedge clk);
      chk("t1_factor", 32'(rot_factor), 32'(k % ROT_NB));
      chk("t1_eob", 32'(rot_eob), 32'(k == CHUNK_NB - 1));
      tick();
    end
    in_vld = 1'b0;
    @(negedge clk);
    chk("t1_idle_rdy", 32'(cmd_rdy), 32'd1);
    repeat (LAT + 1) tick();
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_err_sticky", 32'(err_ovf), 32'd1);

    // Single batch bid=5, one PBS, in_vld held high
    do_reset();
    send_cmd(5, 1);
    run_batch(1, 0, 5, 1);

    // Three two-PBS batches with no credit return: third waits for a credit
    do_reset();
    send_cmd(1, 2);
    run_batch(2, 0, 1, 1);
    send_cmd(2, 2);
    run_batch(2, 512, 2, 0);
    cmd_vld    = 1'b1;
    cmd_bid    = BID_W'(3);
    cmd_pbs_nb = PNB_W'(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_stall_rdy", 32'(cmd_rdy), 32'd0);
      tick();
    end
    credit_ret = 1'b1;
    @(negedge clk);
    chk("t3_ret_cycle_rdy", 32'(cmd_rdy), 32'd0);
    tick();
    credit_ret = 1'b0;
    send_cmd(3, 2);
    run_batch(2, 0, 3, 0);

    // Credit return coinciding with an accept at credit=1, then overflow
    do_reset();
    send_cmd(4, 1);
    run_batch(1, 0, 4, 1);
    cmd_vld    = 1'b1;
    cmd_bid    = BID_W'(6);
    cmd_pbs_nb = PNB_W'(1);
    credit_ret = 1'b1;
    @(negedge clk);
    chk("t4_acc_rdy", 32'(cmd_rdy), 32'd1);
    tick();
    idle_inputs();
    run_batch(1, 512, 6, 1);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    @(negedge clk);
    chk("t4_no_err_yet", 32'(err_ovf), 32'd0);
    tick();
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(err_ovf), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_hold", 32'(err_ovf), 32'd1);
    tick();
    send_cmd(7, 1);
    run_batch(1, 0, 7, 1);
    send_cmd(8, 1);
    run_batch(1, 512, 8, 0);
    @(negedge clk);
    chk("t5_err_after", 32'(err_ovf), 32'd1);
    tick();

    // Reset asserted at beat 10: everything in flight is dropped
    do_reset();
    send_cmd(11, 1);
    for (int k = 0; k < 10; k++) begin
      in_vld = 1'b1;
      tick();
    end
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("t6_rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("t6_rst_avail", 32'(rot_avail), 32'd0);
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    in_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_wr_en", 32'(wr_en), 32'd0);
      tick();
    end
    send_cmd(12, 1);
    run_batch(1, 0, 12, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl.md
Name: ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl

Overview:
- Sequencer for the PCG write dispatch-rotate datapath in the WMM NTT core.
- Accepts one batch command at a time and paces upstream data beats against downstream buffer credits.
- Per accepted beat, issues the rotation command to the rotate datapath in the same cycle.
- Issues the matching RAM write enable/address LAT cycles later, aligned with the rotated data.

Parameters:
- CHUNK_NB, 64, beats per polynomial; power of 2, >=2.
- BATCH_PBS_NB, 8, max PBS per batch; power of 2.
- ROT_NB, 16, rotation factor modulus; power of 2, <= CHUNK_NB.
- BUF_DEPTH, 2, downstream batch slots (credits); power of 2, >=1.
- LAT, 3, datapath latency S0->S3; equals the rotate package get_latency().
- BID_W, 4, batch id width.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  batch command valid
- cmd_rdy  out  1  batch command ready
- cmd_bid  in  BID_W  batch id
- cmd_pbs_nb  in  $clog2(BATCH_PBS_NB)+1  PBS count in batch, 1..BATCH_PBS_NB
- in_vld  in  1  upstream data beat present
- in_rdy  out  1  controller consumes beat
- rot_avail  out  1  rotation command valid (= in_vld & in_rdy)
- rot_factor  out  $clog2(ROT_NB)  rotation amount
- rot_sob  out  1  first beat of batch
- rot_eob  out  1  last beat of batch
- wr_en  out  1  RAM write enable
- wr_add  out  $clog2(BUF_DEPTH*BATCH_PBS_NB*CHUNK_NB)  RAM address
- wr_bid  out  BID_W  batch id of write
- credit_ret  in  1  one downstream slot freed (pulse)
- busy  out  1  state != IDLE or any write in flight
- err_ovf  out  1  sticky, credit return while credits full

Behaviour:
- Reset (async): state IDLE; credit=BUF_DEPTH; slot=0; counters 0.
  - Outputs at reset: cmd_rdy=1, in_rdy=0, rot_*=0, wr_*=0, busy=0, err_ovf=0.
  - Delay-pipe valids cleared: in-flight beats are dropped, no wr_en after reset.
- FSM IDLE:
  - cmd_rdy = (credit != 0).
  - On cmd_vld & cmd_rdy: latch bid and pbs_nb; chunk=0, pbs=0; credit-1; -> RUN.
- FSM RUN:
  - in_rdy=1, cmd_rdy=0.
  - Per accepted beat: chunk++. At chunk==CHUNK_NB-1: chunk=0, pbs++.
  - Last beat (chunk==CHUNK_NB-1 & pbs==pbs_nb-1): slot=(slot+1) mod BUF_DEPTH; -> IDLE.
  - Next command is accepted no earlier than the following cycle (one-cycle bubble by design).
- Rotation output (combinational on the accepted beat):
  - rot_factor = (chunk + pbs) mod ROT_NB.
  - rot_sob = (chunk==0 & pbs==0); rot_eob = last beat.
- Write path:
  - {valid, slot, pbs, chunk, bid} is delayed exactly LAT registered stages.
  - wr_en = delayed valid; wr_add = {slot, pbs, chunk}; wr_bid = delayed bid.
  - wr_en lags the accepted beat by exactly LAT cycles.
- Credits:
  - credit_ret alone: credit+1.
  - Credit decrement and credit_ret in the same cycle: credit unchanged.
  - credit_ret with credit==BUF_DEPTH and no decrement: ignored, err_ovf<=1 until reset.
- in_vld=0 in RUN: counters hold; no timeout.
- cmd_pbs_nb==0 or >BATCH_PBS_NB: out of contract.
- busy = (state!=IDLE) | (any delay-stage valid).

Decomposition:
- Shared package ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_pkg holds:
  - state enum (IDLE, RUN);
  - address-field widths derived from the parameters;
  - LAT constant sourced from the rotate package get_latency().
- One natural sub-module: ntt_core_wmm_dispatch_rotate_wr_pcg_ctrl_dly, a parameterised LAT-deep valid+payload shift pipe with async clear.

Test Plan:
- Single batch: bid=5, pbs_nb=1, in_vld held high.
  -> cmd_rdy drops for 64 cycles.
  -> rot_factor sequence 0..15 repeated 4 times.
  -> rot_eob at beat 63.
  -> wr_en high for 64 cycles starting 3 cycles after first beat, wr_add 0..63, wr_bid=5.
- Three batches (pbs_nb=2 each), no credit_ret:
  -> first two accepted, wr_add bases 0 and 512.
  -> third command stalls (cmd_rdy=0) until credit_ret pulsed, then accepted with slot 0.
- in_vld toggled 1,0,1,0 during RUN:
  -> chunk advances only on high cycles.
  -> wr_en pattern is the same toggle delayed 3 cycles.
- credit_ret in the same cycle as a command accept with credit=1:
  -> credit stays 1.
- credit_ret with credit=2:
  -> err_ovf=1 and stays set; credit stays 2.
- Reset asserted at beat 10 of a batch:
  -> outputs cleared immediately, no wr_en afterwards, cmd_rdy=1.
  -> credit=2 after reset release.
